// File: rtl/sw_debounce_pkg.sv
// Shared constants for the switch-to-ALU operand path: field map, widths and
// the debounce counter sizing helper.
package sw_debounce_pkg;

    localparam int SW_A_LSB   = 0;
    localparam int SW_B_LSB   = 4;
    localparam int SW_SEL_LSB = 8;
    localparam int ALU_NBIT   = 4;
    localparam int SEL_W      = 3;
    localparam int SW_OP_BITS = 11;

    typedef logic [ALU_NBIT-1:0] alu_operand_t;
    typedef logic [SEL_W-1:0]    alu_sel_t;

    // Counter width for a debounce window; never narrower than one bit.
    function automatic int cnt_width(input int deb_cycles);
        int w;
        w = $clog2(deb_cycles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// Single-bit conditioner: two-flop synchronizer, stability counter, stable
// flop and registered rise/fall pulses.
module debounce_bit
    import sw_debounce_pkg::*;
#(
    parameter int DEB_CYCLES = 20000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic stable,
    output logic rise,
    output logic fall,
    output logic flip
);

    localparam int            CW      = cnt_width(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;

    // Combinational so the top can register op_valid on the same edge as stable.
    assign flip = (s2 != stable) && (cnt == CNT_MAX);

    // NOTE: every flop here is state, so all use non-blocking assignments and
    // all clear on reset; a count in progress is deliberately lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            cnt    <= '0;
            stable <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            s1   <= raw;
            s2   <= s1;
            rise <= flip && s2;
            fall <= flip && !s2;
            if (flip) begin
                stable <= s2;
                cnt    <= '0;
            end else if (s2 != stable) begin
                cnt <= cnt + CW'(1);
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/sw_debounce.sv
// Board switch conditioner: per-bit debounce, then ALU operand field slicing
// and a change strobe covering the operand bits only.
module sw_debounce
    import sw_debounce_pkg::*;
#(
    parameter int NSW        = 11,
    parameter int DEB_CYCLES = 20000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NSW-1:0]     sw_raw,
    output logic [NSW-1:0]     sw_stable,
    output logic [NSW-1:0]     sw_rise,
    output logic [NSW-1:0]     sw_fall,
    output alu_operand_t       op_a,
    output alu_operand_t       op_b,
    output alu_sel_t           op_sel,
    output logic               op_valid
);

    localparam logic [NSW-1:0] OP_MASK = NSW'({SW_OP_BITS{1'b1}});

    logic [NSW-1:0] flip;

    if (NSW < SW_OP_BITS) begin : g_bad_nsw
        $error("sw_debounce: NSW must be at least SW_OP_BITS");
    end

    for (genvar i = 0; i < NSW; i++) begin : g_bit
        debounce_bit #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_bit (
            .clk   (clk),
            .rst   (rst),
            .raw   (sw_raw[i]),
            .stable(sw_stable[i]),
            .rise  (sw_rise[i]),
            .fall  (sw_fall[i]),
            .flip  (flip[i])
        );
    end

    // Bits above the operand map are masked so they never raise op_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_valid <= 1'b0;
        end else begin
            op_valid <= |(flip & OP_MASK);
        end
    end

    assign op_a   = sw_stable[SW_A_LSB   +: ALU_NBIT];
    assign op_b   = sw_stable[SW_B_LSB   +: ALU_NBIT];
    assign op_sel = sw_stable[SW_SEL_LSB +: SEL_W];

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce with DEB_CYCLES=4: per-cycle vector table for
// the main sequence plus hand-written reset and wide-NSW sequences.
module tb_sw_debounce;

    localparam int DEB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] sw_raw = '0;
    logic [10:0] sw_stable, sw_rise, sw_fall;
    logic [3:0]  op_a, op_b;
    logic [2:0]  op_sel;
    logic        op_valid;

    logic [11:0] raw12 = '0;
    logic [11:0] stable12, rise12, fall12;
    logic [3:0]  op_a12, op_b12;
    logic [2:0]  op_sel12;
    logic        op_valid12;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sw_debounce #(.NSW(11), .DEB_CYCLES(DEB)) dut (
        .clk(clk), .rst(rst), .sw_raw(sw_raw), .sw_stable(sw_stable),
        .sw_rise(sw_rise), .sw_fall(sw_fall), .op_a(op_a), .op_b(op_b),
        .op_sel(op_sel), .op_valid(op_valid)
    );

    sw_debounce #(.NSW(12), .DEB_CYCLES(DEB)) dut12 (
        .clk(clk), .rst(rst), .sw_raw(raw12), .sw_stable(stable12),
        .sw_rise(rise12), .sw_fall(fall12), .op_a(op_a12), .op_b(op_b12),
        .op_sel(op_sel12), .op_valid(op_valid12)
    );

    typedef struct {
        logic [10:0] raw;
        logic [10:0] stable;
        logic [10:0] rise;
        logic [10:0] fall;
        logic        valid;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic [10:0] raw, input logic [10:0] stable,
                       input logic [10:0] rise, input logic [10:0] fall, input logic valid);
        vec_t v;
        v.raw = raw; v.stable = stable; v.rise = rise; v.fall = fall; v.valid = valid;
        vecs.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_main(input string tag, input logic [10:0] st, input logic [10:0] ri,
                              input logic [10:0] fa, input logic va);
        check({tag, " sw_stable"}, 32'(sw_stable), 32'(st));
        check({tag, " sw_rise"},   32'(sw_rise),   32'(ri));
        check({tag, " sw_fall"},   32'(sw_fall),   32'(fa));
        check({tag, " op_valid"},  32'(op_valid),  32'(va));
        check({tag, " op_a"},      32'(op_a),      32'(st[3:0]));
        check({tag, " op_b"},      32'(op_b),      32'(st[7:4]));
        check({tag, " op_sel"},    32'(op_sel),    32'(st[10:8]));
    endtask

    initial begin
        // 0x005 qualifies on the fifth edge after the first sampling edge.
        for (int i = 0; i < 5; i++) add(11'h005, 11'h000, 11'h000, 11'h000, 1'b0);
        add(11'h005, 11'h005, 11'h005, 11'h000, 1'b1);
        add(11'h005, 11'h005, 11'h000, 11'h000, 1'b0);
        // Bit 9 glitch of 3 cycles: counter reaches DEB-1 but s2 has dropped.
        for (int i = 0; i < 3; i++) add(11'h205, 11'h005, 11'h000, 11'h000, 1'b0);
        for (int i = 0; i < 4; i++) add(11'h005, 11'h005, 11'h000, 11'h000, 1'b0);
        // Multi-bit change in one cycle: one strobe, rise and fall together.
        for (int i = 0; i < 5; i++) add(11'h730, 11'h005, 11'h000, 11'h000, 1'b0);
        add(11'h730, 11'h730, 11'h730, 11'h005, 1'b1);
        add(11'h730, 11'h730, 11'h000, 11'h000, 1'b0);

        // Reset with idle input.
        #2;
        check_main("reset", 11'h0, 11'h0, 11'h0, 1'b0);
        check("reset op_valid12", 32'(op_valid12), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        begin
            int pulses;
            pulses = 0;
            for (int i = 0; i < 20; i++) begin
                step();
                if (sw_rise != 0 || sw_fall != 0 || op_valid || sw_stable != 0) pulses++;
            end
            check("idle no pulses", 32'(pulses), 32'd0);
        end

        foreach (vecs[i]) begin
            @(negedge clk);
            sw_raw = vecs[i].raw;
            step();
            check_main($sformatf("vec%0d", i), vecs[i].stable, vecs[i].rise,
                       vecs[i].fall, vecs[i].valid);
        end

        // Reset mid-count with bit 0 held high through release.
        @(negedge clk);
        rst = 1'b1;
        sw_raw = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        sw_raw = 11'h001;
        step();
        step();
        #2;
        rst = 1'b1;
        #1;
        check_main("async rst", 11'h0, 11'h0, 11'h0, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int e = 0; e < DEB + 1; e++) begin
            step();
            check($sformatf("post-rst edge%0d stable", e), 32'(sw_stable), 32'd0);
            check($sformatf("post-rst edge%0d rise", e), 32'(sw_rise), 32'd0);
        end
        step();
        check_main("post-rst flip", 11'h001, 11'h001, 11'h000, 1'b1);
        step();
        check_main("post-rst after", 11'h001, 11'h000, 11'h000, 1'b0);

        // NSW=12: bit 11 follows its own debounce but never strobes op_valid.
        @(negedge clk);
        raw12 = 12'h800;
        begin
            int strobes;
            strobes = 0;
            for (int e = 0; e < DEB + 1; e++) begin
                step();
                if (op_valid12) strobes++;
            end
            check("nsw12 pre stable", 32'(stable12), 32'h000);
            step();
            if (op_valid12) strobes++;
            check("nsw12 stable", 32'(stable12), 32'h800);
            check("nsw12 rise", 32'(rise12), 32'h800);
            check("nsw12 op_sel", 32'(op_sel12), 32'd0);
            @(negedge clk);
            raw12 = 12'h000;
            for (int e = 0; e < DEB + 1; e++) begin
                step();
                if (op_valid12) strobes++;
            end
            step();
            if (op_valid12) strobes++;
            check("nsw12 fall", 32'(fall12), 32'h800);
            check("nsw12 stable low", 32'(stable12), 32'h000);
            check("nsw12 op_valid", 32'(strobes), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sw_debounce.md
# sw_debounce

Input-side conditioner for the board switches that feed the ALU top level. It synchronizes the 11 raw slide-switch inputs to `clk` and debounces each bit independently with a per-bit stability counter. It then presents the clean bits as ALU operand fields `op_a`, `op_b` and `op_sel`, together with a single-cycle `op_valid` strobe whenever any operand bit changes. It sits between the board pins and the ALU operand ports, mirroring the LED result path on the output side.

## Interface
- `NSW`, 11: number of switch inputs; must be ≥ 11 for the fixed operand field map.
- `DEB_CYCLES`, 20000: consecutive cycles a synchronized bit must disagree with its stable value before the stable value flips; legal range ≥ 2.
- `clk`  input  1  system clock; all state on rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `sw_raw`  input  NSW  raw switch levels, asynchronous to `clk`.
- `sw_stable`  output  NSW  debounced switch levels.
- `sw_rise`  output  NSW  per-bit one-cycle pulse; bit's stable value went 0→1.
- `sw_fall`  output  NSW  per-bit one-cycle pulse; bit's stable value went 1→0.
- `op_a`  output  4  `sw_stable[3:0]`.
- `op_b`  output  4  `sw_stable[7:4]`.
- `op_sel`  output  3  `sw_stable[10:8]`.
- `op_valid`  output  1  one-cycle pulse when any of `sw_stable[10:0]` changes.

## Operation
- Per bit: two-flop synchronizer `s1 <- sw_raw`, `s2 <- s1`. Neither flop is used for anything else.
- Each bit has a counter of width `$clog2(DEB_CYCLES)`.
- When `s2 != stable` and `cnt == DEB_CYCLES-1`:
  - `stable <= s2` and `cnt <= 0`.
  - Assert `rise` (new value 1) or `fall` (new value 0) on the same edge.
- When `s2 != stable` and `cnt != DEB_CYCLES-1`: `cnt <= cnt + 1`.
- When `s2 == stable`: `cnt <= 0`. Any glitch shorter than `DEB_CYCLES` cycles is discarded completely; there is no partial credit.
- `op_valid` is registered. It is high for one cycle, on the same edge as `sw_stable` updates, if any bit in [10:0] flips.
- Multiple bits flipping on the same edge produce one `op_valid` pulse, with every affected `rise`/`fall` bit set together.
- Bits at index ≥ 11 update `sw_stable`, `sw_rise` and `sw_fall` but never `op_valid`.
- `op_a`, `op_b` and `op_sel` are pure wiring from `sw_stable`. They have no extra latency.
- The counter never wraps. It is cleared either on flip or on agreement.

## Timing
- Reset values: `s1`, `s2`, `sw_stable`, counters, `sw_rise`, `sw_fall` and `op_valid` are all 0. Consequently `op_a`, `op_b` and `op_sel` are 0.
- Latency (edges numbered from the first edge that samples the new raw level as edge 0):
  - `s2` takes the new level at edge 1.
  - Mismatch is counted at edges 2 … `DEB_CYCLES`+1.
  - `sw_stable` and its pulses update at edge `DEB_CYCLES`+1, so total latency is `DEB_CYCLES`+1 edges.
- Pulses are high exactly one cycle and deassert on the next edge. Back-to-back pulses on one bit are impossible; the minimum spacing is `DEB_CYCLES` cycles.
- Reset mid-count: everything clears asynchronously and the count in progress is lost.
  - If `sw_raw` bit is 1 through reset release, the bit re-qualifies as a fresh 0→1 change.
  - That produces `rise` and `op_valid` `DEB_CYCLES`+1 edges after the first post-release edge.
- A raw bit that returns to its stable value on the same edge the counter would hit `DEB_CYCLES-1` causes no flip. The comparison uses `s2` at that edge.

## Structure
- Shared package holds:
  - field constants `SW_A_LSB=0`, `SW_B_LSB=4`, `SW_SEL_LSB=8`;
  - widths `ALU_NBIT=4`, `SEL_W=3`;
  - `SW_OP_BITS=11`.
- One sub-module, `debounce_bit`: synchronizer, counter, stable flop and rise/fall for a single bit, parameterized by `DEB_CYCLES`. It is generate-instantiated `NSW` times.
- The top module only does the `op_valid` OR-reduction, its register, and the field slicing.

## Test plan
All directed scenarios use `DEB_CYCLES=4`.
- Reset with `sw_raw=0` → all outputs 0; after release with input idle for 20 cycles, there are no pulses.
- `sw_raw` 0x000→0x005 held → at edge 5: `sw_stable=0x005`, `op_a=5`, `sw_rise=0x005`, `op_valid=1` for one cycle.
- `sw_raw[9]` glitches high for 3 cycles then low → `sw_stable`, `sw_rise` and `op_valid` never change.
- `sw_raw` 0x005→0x730 applied in one cycle → a single `op_valid`; `op_sel=7`, `op_b=3`, `op_a=0`; `sw_rise=0x730`, `sw_fall=0x005` on the same cycle.
- `rst` asserted 2 cycles after `sw_raw[0]` rises, then released with the bit still 1 → no flip before reset; `sw_rise[0]` arrives 5 edges after release.
- `NSW=12`, toggle `sw_raw[11]` → `sw_stable[11]` and `sw_rise[11]` follow, `op_valid` stays 0.
